// File: rtl/spi_master_ifc_if.sv
// Bundle of SPI master control, serial-link and buffer-memory signals.
// The master modport faces the SPI master; the slave modport faces its environment.
interface spi_master_ifc_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W:0]   xferLen;
    logic              busy;
    logic              done;
    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic              SPI_MISO;
    logic              SPI_SS;
    logic [ADDR_W-1:0] txMemAddr;
    logic [7:0]        txMemData;
    logic [ADDR_W-1:0] rcMemAddr;
    logic [7:0]        rcMemData;
    logic              rcMemWE;

    modport master (
        input  start, xferLen, SPI_MISO, txMemData,
        output busy, done, SPI_CLK, SPI_MOSI, SPI_SS,
               txMemAddr, rcMemAddr, rcMemData, rcMemWE
    );

    modport slave (
        output start, xferLen, SPI_MISO, txMemData,
        input  busy, done, SPI_CLK, SPI_MOSI, SPI_SS,
               txMemAddr, rcMemAddr, rcMemData, rcMemWE
    );
endinterface

// File: rtl/spi_master_ifc.sv
// Mode-0 SPI master: streams xferLen bytes from the tx buffer onto MOSI while
// capturing the same number of bytes from MISO into the rx buffer.
module spi_master_ifc #(
    parameter int ADDR_W  = 12,
    parameter int CLK_DIV = 4
) (
    input  logic                 SysClk,
    input  logic                 Reset_n,
    spi_master_ifc_if.master     bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        LOW   = 3'd3,
        HIGH  = 3'd4,
        STORE = 3'd5,
        HOLD  = 3'd6,
        DONE  = 3'd7
    } state_t;

    // Every output is a field of this register, so outputs never see comb logic.
    typedef struct packed {
        state_t            state;
        logic [DIV_W-1:0]  div;
        logic [2:0]        bitn;
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W:0]   len;
        logic [7:0]        tx_sr;
        logic [7:0]        rx_sr;
        logic              busy;
        logic              done;
        logic              sclk;
        logic              mosi;
        logic              ss;
        logic              we;
        logic [ADDR_W-1:0] tx_addr;
        logic [ADDR_W-1:0] rc_addr;
        logic [7:0]        rc_data;
    } regs_t;

    regs_t r, n;
    logic  div_end;

    assign div_end = (r.div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r    <= '0;
            r.ss <= 1'b1;
        end else begin
            r <= n;
        end
    end

    always_comb begin
        n      = r;
        n.done = 1'b0;
        n.we   = 1'b0;
        case (r.state)
            IDLE: begin
                if (bus.start) begin
                    n.busy = 1'b1;
                    if (bus.xferLen != '0) begin
                        n.len     = bus.xferLen;
                        n.idx     = '0;
                        n.tx_addr = '0;
                        n.state   = FETCH;
                    end else begin
                        n.state = DONE;
                    end
                end
            end
            FETCH: n.state = LOAD;
            LOAD: begin
                n.tx_sr = bus.txMemData;
                n.mosi  = bus.txMemData[7];
                n.ss    = 1'b0;
                n.bitn  = '0;
                n.div   = '0;
                n.state = LOW;
            end
            LOW: begin
                if (div_end) begin
                    n.div   = '0;
                    n.sclk  = 1'b1;
                    n.rx_sr = {r.rx_sr[6:0], bus.SPI_MISO};
                    n.state = HIGH;
                end else begin
                    n.div = r.div + 1'b1;
                end
            end
            HIGH: begin
                if (div_end) begin
                    n.div  = '0;
                    n.sclk = 1'b0;
                    if (r.bitn != 3'd7) begin
                        n.bitn  = r.bitn + 3'd1;
                        n.tx_sr = {r.tx_sr[6:0], 1'b0};
                        n.mosi  = r.tx_sr[6];
                        n.state = LOW;
                    end else begin
                        n.state = STORE;
                    end
                end else begin
                    n.div = r.div + 1'b1;
                end
            end
            STORE: begin
                n.we      = 1'b1;
                n.rc_addr = r.idx;
                n.rc_data = r.rx_sr;
                // idx is zero-extended so len = 2^ADDR_W terminates at the top address.
                if ({1'b0, r.idx} == r.len - 1'b1) begin
                    n.div   = '0;
                    n.state = HOLD;
                end else begin
                    n.idx     = r.idx + 1'b1;
                    n.tx_addr = r.idx + 1'b1;
                    n.state   = FETCH;
                end
            end
            HOLD: begin
                if (div_end) begin
                    n.div   = '0;
                    n.ss    = 1'b1;
                    n.state = DONE;
                end else begin
                    n.div = r.div + 1'b1;
                end
            end
            DONE: begin
                n.done  = 1'b1;
                n.busy  = 1'b0;
                n.state = IDLE;
            end
            default: n.state = IDLE;
        endcase
    end

    assign bus.busy      = r.busy;
    assign bus.done      = r.done;
    assign bus.SPI_CLK   = r.sclk;
    assign bus.SPI_MOSI  = r.mosi;
    assign bus.SPI_SS    = r.ss;
    assign bus.txMemAddr = r.tx_addr;
    assign bus.rcMemAddr = r.rc_addr;
    assign bus.rcMemData = r.rc_data;
    assign bus.rcMemWE   = r.we;
endmodule

// File: tb/tb_spi_master_ifc.sv
// Directed bench for spi_master_ifc: a CLK_DIV=4/ADDR_W=12 instance and a
// CLK_DIV=1/ADDR_W=4 instance, each with buffer memories and a simple slave.
module tb_spi_master_ifc;
    logic SysClk  = 1'b0;
    logic Reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 SysClk = ~SysClk;

    spi_master_ifc_if #(.ADDR_W(12)) bus ();
    spi_master_ifc_if #(.ADDR_W(4))  bus2 ();

    spi_master_ifc #(.ADDR_W(12), .CLK_DIV(4)) dut (
        .SysClk(SysClk), .Reset_n(Reset_n), .bus(bus)
    );
    spi_master_ifc #(.ADDR_W(4), .CLK_DIV(1)) dut2 (
        .SysClk(SysClk), .Reset_n(Reset_n), .bus(bus2)
    );

    // ---------------- environment for dut ----------------
    logic [7:0]  txmem [0:4095];
    logic [7:0]  rcmem [0:4095];
    logic        mosi_log [0:63];
    int          clk_edges = 0, we_cnt = 0, done_cnt = 0, ss_fall = 0, ss_bad = 0;
    longint      last_edge = 0, last_per = 0;
    logic [11:0] last_we_addr = '0;
    logic        loopback = 1'b0;
    logic [7:0]  slave_byte = 8'h00;
    logic [2:0]  sbit = 3'd0;

    always @(posedge SysClk) bus.txMemData <= txmem[bus.txMemAddr];

    always @(posedge SysClk) begin
        if (bus.rcMemWE === 1'b1) begin
            rcmem[bus.rcMemAddr] <= bus.rcMemData;
            we_cnt       <= we_cnt + 1;
            last_we_addr <= bus.rcMemAddr;
        end
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    always @(posedge bus.SPI_CLK) begin
        mosi_log[clk_edges[5:0]] <= bus.SPI_MOSI;
        clk_edges <= clk_edges + 1;
        last_per  <= $time - last_edge;
        last_edge <= $time;
        if (bus.SPI_SS !== 1'b0) ss_bad <= ss_bad + 1;
    end

    always @(negedge bus.SPI_SS) ss_fall <= ss_fall + 1;

    // Mode-0 slave: presents MSB first, advances on each falling SPI_CLK.
    always @(negedge bus.SPI_CLK or posedge bus.SPI_SS)
        if (bus.SPI_SS) sbit <= 3'd0;
        else            sbit <= sbit + 3'd1;

    assign bus.SPI_MISO = loopback ? bus.SPI_MOSI : slave_byte[3'd7 - sbit];

    // ---------------- environment for dut2 (loopback) ----------------
    logic [7:0] tx2 [0:15];
    logic [7:0] rc2 [0:15];
    int         we2_cnt = 0, done2_cnt = 0;
    longint     last_edge2 = 0, last_per2 = 0;
    logic [3:0] last_we2_addr = '0;

    always @(posedge SysClk) bus2.txMemData <= tx2[bus2.txMemAddr];

    always @(posedge SysClk) begin
        if (bus2.rcMemWE === 1'b1) begin
            rc2[bus2.rcMemAddr] <= bus2.rcMemData;
            we2_cnt       <= we2_cnt + 1;
            last_we2_addr <= bus2.rcMemAddr;
        end
        if (bus2.done === 1'b1) done2_cnt <= done2_cnt + 1;
    end

    always @(posedge bus2.SPI_CLK) begin
        last_per2  <= $time - last_edge2;
        last_edge2 <= $time;
    end

    assign bus2.SPI_MISO = bus2.SPI_MOSI;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int len);
        @(negedge SysClk);
        bus.start   = 1'b1;
        bus.xferLen = 13'(len);
        @(negedge SysClk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit second, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge SysClk);
            #1;
            if ((second ? bus2.done : bus.done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        // let the monitors register the done cycle
        @(posedge SysClk);
        #1;
    endtask

    initial begin
        bit          seen;
        int          b_clk, b_we, b_done, b_fall, b_bad;
        logic [7:0]  mbyte;

        bus.start    = 1'b0;
        bus.xferLen  = '0;
        bus2.start   = 1'b0;
        bus2.xferLen = '0;

        // 1. reset state while held and after release
        repeat (3) @(negedge SysClk);
        chk("rst_ss",   32'(bus.SPI_SS),   32'd1);
        chk("rst_clk",  32'(bus.SPI_CLK),  32'd0);
        chk("rst_mosi", 32'(bus.SPI_MOSI), 32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_done", 32'(bus.done),     32'd0);
        chk("rst_we",   32'(bus.rcMemWE),  32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge SysClk);
        chk("post_rst_ss",   32'(bus.SPI_SS), 32'd1);
        chk("post_rst_busy", 32'(bus.busy),   32'd0);

        // 2. single byte 0xA5 out, slave returns 0x3C
        txmem[0]   = 8'hA5;
        slave_byte = 8'h3C;
        loopback   = 1'b0;
        b_clk = clk_edges; b_we = we_cnt; b_done = done_cnt; b_fall = ss_fall; b_bad = ss_bad;
        kick(1);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        wait_done(1'b0, 2000, seen);
        chk("t2_done_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 8; k++) mbyte[7-k] = mosi_log[(b_clk + k) % 64];
        chk("t2_mosi_bits", 32'(mbyte), 32'hA5);
        chk("t2_clk_edges", 32'(clk_edges - b_clk), 32'd8);
        chk("t2_clk_per",   32'(last_per), 32'd80);
        chk("t2_we_cnt",    32'(we_cnt - b_we), 32'd1);
        chk("t2_we_addr",   32'(last_we_addr), 32'd0);
        chk("t2_rx_data",   32'(rcmem[0]), 32'h3C);
        chk("t2_done_cnt",  32'(done_cnt - b_done), 32'd1);
        chk("t2_ss_fall",   32'(ss_fall - b_fall), 32'd1);
        chk("t2_ss_low",    32'(ss_bad - b_bad), 32'd0);
        chk("t2_busy_end",  32'(bus.busy), 32'd0);
        chk("t2_ss_end",    32'(bus.SPI_SS), 32'd1);

        // 3. four-byte loopback
        loopback = 1'b1;
        txmem[0] = 8'h01; txmem[1] = 8'h02; txmem[2] = 8'h80; txmem[3] = 8'hFF;
        b_clk = clk_edges; b_we = we_cnt; b_done = done_cnt; b_fall = ss_fall; b_bad = ss_bad;
        kick(4);
        chk("t3_busy", 32'(bus.busy), 32'd1);
        wait_done(1'b0, 4000, seen);
        chk("t3_done_seen", 32'(seen), 32'd1);
        chk("t3_clk_edges", 32'(clk_edges - b_clk), 32'd32);
        chk("t3_we_cnt",    32'(we_cnt - b_we), 32'd4);
        chk("t3_we_addr",   32'(last_we_addr), 32'd3);
        chk("t3_ss_fall",   32'(ss_fall - b_fall), 32'd1);
        chk("t3_ss_low",    32'(ss_bad - b_bad), 32'd0);
        chk("t3_rc0", 32'(rcmem[0]), 32'h01);
        chk("t3_rc1", 32'(rcmem[1]), 32'h02);
        chk("t3_rc2", 32'(rcmem[2]), 32'h80);
        chk("t3_rc3", 32'(rcmem[3]), 32'hFF);
        chk("t3_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("t3_mosi_held", 32'(bus.SPI_MOSI), 32'd1);

        // 4. zero-length transfer: DONE entered, done on the following cycle
        b_clk = clk_edges; b_we = we_cnt; b_done = done_cnt; b_fall = ss_fall;
        kick(0);
        chk("t4_busy",      32'(bus.busy), 32'd1);
        chk("t4_done_early", 32'(bus.done), 32'd0);
        @(negedge SysClk);
        chk("t4_done_pulse", 32'(bus.done), 32'd1);
        chk("t4_busy_clr",   32'(bus.busy), 32'd0);
        @(negedge SysClk);
        chk("t4_done_once", 32'(bus.done), 32'd0);
        repeat (2) @(negedge SysClk);
        chk("t4_done_cnt",  32'(done_cnt - b_done), 32'd1);
        chk("t4_no_clk",    32'(clk_edges - b_clk), 32'd0);
        chk("t4_no_we",     32'(we_cnt - b_we), 32'd0);
        chk("t4_no_ss",     32'(ss_fall - b_fall), 32'd0);

        // 5a. start hammered during a 2-byte transfer
        txmem[0] = 8'h11; txmem[1] = 8'h22;
        b_clk = clk_edges; b_we = we_cnt; b_done = done_cnt;
        kick(2);
        for (int p = 0; p < 5; p++) begin
            repeat (20) @(negedge SysClk);
            bus.start   = 1'b1;
            bus.xferLen = 13'd1;
            @(negedge SysClk);
            bus.start = 1'b0;
        end
        wait_done(1'b0, 3000, seen);
        chk("t5_done_seen", 32'(seen), 32'd1);
        chk("t5_we_cnt",    32'(we_cnt - b_we), 32'd2);
        chk("t5_clk_edges", 32'(clk_edges - b_clk), 32'd16);
        chk("t5_done_cnt",  32'(done_cnt - b_done), 32'd1);
        chk("t5_rc0", 32'(rcmem[0]), 32'h11);
        chk("t5_rc1", 32'(rcmem[1]), 32'h22);

        // 5b. asynchronous reset after the 3rd rising edge of byte 0
        b_clk = clk_edges; b_we = we_cnt;
        kick(1);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge SysClk);
            if (clk_edges - b_clk >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_third_edge", 32'(seen), 32'd1);
        @(posedge SysClk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("t5r_ss",   32'(bus.SPI_SS),   32'd1);
        chk("t5r_clk",  32'(bus.SPI_CLK),  32'd0);
        chk("t5r_mosi", 32'(bus.SPI_MOSI), 32'd0);
        chk("t5r_busy", 32'(bus.busy),     32'd0);
        chk("t5r_we",   32'(bus.rcMemWE),  32'd0);
        repeat (2) @(negedge SysClk);
        Reset_n = 1'b1;
        repeat (2) @(negedge SysClk);
        chk("t5r_no_store", 32'(we_cnt - b_we), 32'd0);
        txmem[0] = 8'h5A;
        b_we = we_cnt; b_done = done_cnt;
        kick(1);
        wait_done(1'b0, 2000, seen);
        chk("t5r_done_seen", 32'(seen), 32'd1);
        chk("t5r_we_cnt",    32'(we_cnt - b_we), 32'd1);
        chk("t5r_rc0",       32'(rcmem[0]), 32'h5A);
        chk("t5r_done_cnt",  32'(done_cnt - b_done), 32'd1);

        // 6. full 16-byte buffer on the ADDR_W=4, CLK_DIV=1 instance
        for (int i = 0; i < 16; i++) tx2[i] = 8'(i) ^ 8'hC6;
        b_we = we2_cnt; b_done = done2_cnt;
        @(negedge SysClk);
        bus2.start   = 1'b1;
        bus2.xferLen = 5'd16;
        @(negedge SysClk);
        bus2.start = 1'b0;
        wait_done(1'b1, 2000, seen);
        chk("t6_done_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 16; i++) chk($sformatf("t6_rc%0d", i), 32'(rc2[i]), 32'(8'(i) ^ 8'hC6));
        chk("t6_we_cnt",   32'(we2_cnt - b_we), 32'd16);
        chk("t6_we_addr",  32'(last_we2_addr), 32'd15);
        chk("t6_done_cnt", 32'(done2_cnt - b_done), 32'd1);
        chk("t6_clk_per",  32'(last_per2), 32'd20);
        chk("t6_ss_end",   32'(bus2.SPI_SS), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
